// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out LSB-first, repeated reps times.
// Optional `define SEQGEN_REF_EN adds exp_y, a registered 111/000 Moore detector golden model.
module seq_pattern_gen #(
  parameter int unsigned W  = 16,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  pattern,
  input  logic [4:0]    len,
  input  logic [RW-1:0] reps,
  input  logic          idle_val,
  output logic          x,
  output logic          valid,
  output logic          busy,
`ifdef SEQGEN_REF_EN
  output logic          exp_y,
`endif
  output logic          done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e        state_q;
  logic [W-1:0]  pat_q;
  logic [4:0]    len_q;
  logic [RW-1:0] reps_q;
  logic [CW-1:0] bit_cnt_q;
  logic [RW-1:0] rep_cnt_q;
  logic          idle_q;

  logic [4:0]    len_d;
  logic [RW-1:0] reps_d;
  logic          start_ok;
  logic          last_bit;
  logic          last_rep;

  always_comb begin
    len_d    = (32'(len) > W) ? 5'(W) : len;
    reps_d   = (reps == '0) ? RW'(1) : reps;
    start_ok = (state_q == IDLE) && start && (len != '0);
    last_bit = (5'(bit_cnt_q) == (len_q - 5'd1));
    last_rep = (rep_cnt_q == (reps_q - RW'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      idle_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            pat_q     <= pattern;
            len_q     <= len_d;
            reps_q    <= reps_d;
            idle_q    <= idle_val;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            state_q   <= SEND;
          end
        end
        SEND: begin
          // abort wins over the end-of-stream transition
          if (abort) begin
            state_q <= IDLE;
          end else if (last_bit) begin
            bit_cnt_q <= '0;
            if (last_rep) state_q <= DONE;
            else          rep_cnt_q <= rep_cnt_q + RW'(1);
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x     = (state_q == SEND) ? pat_q[bit_cnt_q] : idle_q;
  assign valid = (state_q == SEND);
  assign busy  = (state_q == SEND);
  assign done  = (state_q == DONE);

`ifdef SEQGEN_REF_EN
  logic [1:0] run_q;
  logic [1:0] run_d;
  logic       last_q;
  logic       exp_y_q;

  always_comb begin
    run_d = 2'd1;
    if (x == last_q) run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= '0;
      last_q  <= 1'b0;
      exp_y_q <= 1'b0;
    end else if (start_ok) begin
      run_q   <= '0;
      last_q  <= 1'b0;
      exp_y_q <= 1'b0;
    end else if (valid) begin
      run_q   <= run_d;
      last_q  <= x;
      exp_y_q <= (run_d == 2'd3);
    end else begin
      exp_y_q <= 1'b0;
    end
  end

  assign exp_y = exp_y_q;
`endif

endmodule
